// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// BCD M:SS countdown timer (0:00 .. 9:59) feeding the three-digit 7-segment
// decoder stage. A preset is loaded, then decremented once per `tick` pulse
// while in RUN. Supports load / start / stop (pause) / clear and emits a
// one-cycle `done` pulse when the count reaches 0:00 from RUN.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   tick         in   one-clk-wide 1 Hz enable
//   load         in   load preset digits (ignored in RUN)
//   start        in   begin / resume counting (IDLE or PAUSE, count != 0:00)
//   stop         in   pause counting (RUN only)
//   clear        in   synchronous clear to 0:00 / IDLE
//   min_in       in   [3:0] preset minutes, BCD (clamped to 9)
//   sec_tens_in  in   [3:0] preset tens of seconds, BCD (clamped to 5)
//   sec_ones_in  in   [3:0] preset ones of seconds, BCD (clamped to 9)
//   min          out  [3:0] current minutes digit
//   sec_tens     out  [3:0] current tens-of-seconds digit
//   sec_ones     out  [3:0] current ones-of-seconds digit
//   running      out  high while in RUN (registered)
//   done         out  one-cycle pulse on reaching 0:00 from RUN (registered)
//
// Control priority in one cycle: clear > load > stop > start > tick.
// ---------------------------------------------------------------------------
module countdown_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [3:0] min_in,
    input  logic [3:0] sec_tens_in,
    input  logic [3:0] sec_ones_in,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] min_nxt, tens_nxt, ones_nxt;
    logic       done_nxt;

    // Decremented value of the current count, computed unconditionally and
    // selected in the next-state logic only when a tick is accepted.
    logic [3:0] min_dec, tens_dec, ones_dec;
    logic       dec_hits_zero;
    logic       count_is_zero;
    logic       any_ctrl;

    // Clamp a BCD preset digit to its legal maximum.
    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign count_is_zero = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);

    // Any asserted higher-priority control masks the tick, even if that
    // control itself is ignored in the current state.
    assign any_ctrl = clear | load | stop | start;

    // BCD borrow chain. RUN is never entered or held at 0:00, so the minute
    // borrow cannot underflow.
    always_comb begin
        min_dec  = min;
        tens_dec = sec_tens;
        ones_dec = sec_ones;
        if (sec_ones != 4'd0) begin
            ones_dec = sec_ones - 4'd1;
        end else begin
            ones_dec = 4'd9;
            if (sec_tens != 4'd0) begin
                tens_dec = sec_tens - 4'd1;
            end else begin
                tens_dec = 4'd5;
                min_dec  = (min != 4'd0) ? (min - 4'd1) : 4'd0;
            end
        end
    end

    assign dec_hits_zero = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

    // Next-state / next-digit logic.
    always_comb begin
        state_nxt = state;
        min_nxt   = min;
        tens_nxt  = sec_tens;
        ones_nxt  = sec_ones;
        done_nxt  = 1'b0;

        if (clear) begin
            state_nxt = IDLE;
            min_nxt   = 4'd0;
            tens_nxt  = 4'd0;
            ones_nxt  = 4'd0;
        end else if (load && state != RUN) begin
            state_nxt = IDLE;
            min_nxt   = clamp(min_in, 4'd9);
            tens_nxt  = clamp(sec_tens_in, 4'd5);
            ones_nxt  = clamp(sec_ones_in, 4'd9);
        end else if (stop && state == RUN) begin
            state_nxt = PAUSE;
        end else if (start && (state == IDLE || state == PAUSE)) begin
            if (!count_is_zero) begin
                state_nxt = RUN;
            end
        end else if (tick && !any_ctrl && state == RUN) begin
            min_nxt  = min_dec;
            tens_nxt = tens_dec;
            ones_nxt = ones_dec;
            if (dec_hits_zero) begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
            end
        end
    end

    // State, digit and flag registers. `running` decodes the next state so it
    // lines up with the registered state rather than lagging it by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            min      <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            min      <= min_nxt;
            sec_tens <= tens_nxt;
            sec_ones <= ones_nxt;
            running  <= (state_nxt == RUN);
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Directed self-checking bench for countdown_timer. Inputs are driven on the
// falling edge, held across one rising edge, and outputs are checked on the
// following falling edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    logic       clk;
    logic       rst_n;
    logic       tick, load, start, stop, clear;
    logic [3:0] min_in, sec_tens_in, sec_ones_in;
    logic [3:0] min, sec_tens, sec_ones;
    logic       running, done;

    int total = 0;
    int bad   = 0;

    countdown_timer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .load        (load),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .min_in      (min_in),
        .sec_tens_in (sec_tens_in),
        .sec_ones_in (sec_ones_in),
        .min         (min),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {min, sec_tens, sec_ones, running, done} against expectations.
    task automatic chk(input string tag, input logic [3:0] m, input logic [3:0] t,
                       input logic [3:0] o, input logic r, input logic d);
        logic [13:0] obs, exp;
        obs = {min, sec_tens, sec_ones, running, done};
        exp = {m, t, o, r, d};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h:%h%h run=%b done=%b expected=%h:%h%h run=%b done=%b",
                   tag, min, sec_tens, sec_ones, running, done, m, t, o, r, d);
        end
    endtask

    // One clock with the given controls, then release them.
    task automatic cyc(input logic c, input logic l, input logic sp,
                       input logic st, input logic tk);
        clear = c; load = l; stop = sp; start = st; tick = tk;
        @(posedge clk);
        @(negedge clk);
        clear = 0; load = 0; stop = 0; start = 0; tick = 0;
    endtask

    task automatic do_load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        min_in = m; sec_tens_in = t; sec_ones_in = o;
        cyc(0, 1, 0, 0, 0);
    endtask

    initial begin
        // Reset held with random inputs.
        rst_n = 1'b0;
        tick = 1'($urandom); load = 1'($urandom); start = 1'($urandom);
        stop = 1'($urandom); clear = 1'($urandom);
        min_in = 4'($urandom); sec_tens_in = 4'($urandom); sec_ones_in = 4'($urandom);
        #23;
        chk("reset_hold", 0, 0, 0, 0, 0);
        @(negedge clk);
        tick = 0; load = 0; start = 0; stop = 0; clear = 0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_idle5", 0, 0, 0, 0, 0);

        // Basic countdown from 2:18.
        do_load(4'd2, 4'd1, 4'd8);
        chk("load_218", 2, 1, 8, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("start_218", 2, 1, 8, 1, 0);
        cyc(0, 0, 0, 0, 1); chk("tick_217", 2, 1, 7, 1, 0);
        cyc(0, 0, 0, 0, 1); chk("tick_216", 2, 1, 6, 1, 0);
        cyc(0, 0, 0, 0, 1); chk("tick_215", 2, 1, 5, 1, 0);

        // Load while running is ignored.
        do_load(4'd1, 4'd0, 4'd0);
        chk("load_in_run", 2, 1, 5, 1, 0);
        cyc(0, 0, 1, 0, 0);
        chk("stop_215", 2, 1, 5, 0, 0);

        // Borrow chain 1:00 -> 0:59.
        do_load(4'd1, 4'd0, 4'd0);
        chk("load_100", 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("borrow_059", 0, 5, 9, 1, 0);

        // 2:10 with 11 ticks -> 1:59.
        cyc(0, 0, 1, 0, 0);
        do_load(4'd2, 4'd1, 4'd0);
        cyc(0, 0, 0, 1, 0);
        repeat (10) cyc(0, 0, 0, 0, 1);
        chk("ticks10_200", 2, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("ticks11_159", 1, 5, 9, 1, 0);

        // stop with tick: pause without decrement.
        cyc(0, 0, 1, 0, 1);
        chk("stop_tick", 1, 5, 9, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);
        chk("pause_ticks", 1, 5, 9, 0, 0);
        cyc(0, 0, 0, 1, 1);
        chk("start_tick", 1, 5, 9, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("resume_158", 1, 5, 8, 1, 0);

        // Completion.
        cyc(0, 0, 1, 0, 0);
        do_load(4'd0, 4'd0, 4'd2);
        cyc(0, 0, 0, 1, 0);
        chk("start_002", 0, 0, 2, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("tick_001", 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("done_pulse", 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("done_drop", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("done_tick", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("done_start", 0, 0, 0, 0, 0);

        // Sanitising from DONE: 12:7F -> 9:59.
        do_load(4'd12, 4'd7, 4'd15);
        chk("sanitise", 9, 5, 9, 0, 0);

        // Clear, then start at 0:00 is ignored.
        cyc(1, 0, 0, 0, 0);
        chk("clear_idle", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("start_zero", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("zero_tick", 0, 0, 0, 0, 0);

        // Clear during RUN.
        do_load(4'd0, 4'd3, 4'd0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("run_029", 0, 2, 9, 1, 0);
        cyc(1, 0, 0, 0, 1);
        chk("clear_run", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("clear_tick", 0, 0, 0, 0, 0);

        // Asynchronous reset mid-RUN, between clock edges.
        do_load(4'd5, 4'd0, 4'd0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("run_459", 4, 5, 9, 1, 0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 1);
        chk("post_rst", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("post_rst_start", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD minutes:seconds countdown timer that produces the `min`, `sec_tens` and `sec_ones` digits consumed by the three-digit 7-segment decoder stage. It holds a preset time of M:SS (0:00–9:59) and decrements it once per one-second enable pulse while running. It supports load, start, pause and clear, and flags completion. All outputs are registered, so the downstream decoder sees glitch-free digit codes.

## Interface
- No parameters. The tick rate is supplied externally through `tick`, so the block is prescaler-agnostic.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick` input 1: one-`clk`-wide pulse, nominally 1 Hz; the timer decrements only on cycles where `tick`=1.
- `load` input 1: loads the preset digits.
- `start` input 1: begins or resumes counting.
- `stop` input 1: pauses counting.
- `clear` input 1: synchronous clear to 0:00 and IDLE.
- `min_in` input 4: preset minutes, BCD.
- `sec_tens_in` input 4: preset tens of seconds, BCD.
- `sec_ones_in` input 4: preset ones of seconds, BCD.
- `min` output 4: current minutes digit, BCD 0–9.
- `sec_tens` output 4: current tens-of-seconds digit, BCD 0–5.
- `sec_ones` output 4: current ones-of-seconds digit, BCD 0–9.
- `running` output 1: high in RUN state.
- `done` output 1: one-cycle pulse when the count reaches 0:00 from RUN.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- Control priority within one cycle: `clear` > `load` > `stop` > `start` > `tick`.
- `clear`: digits become 0:00 and the state becomes IDLE, from any state.
- `load`: allowed in IDLE, PAUSE and DONE. Digits take the preset values and the state becomes IDLE. `load` is ignored in RUN.
- Preset sanitising:
  - `min_in` > 9 is stored as 9.
  - `sec_tens_in` > 5 is stored as 5.
  - `sec_ones_in` > 9 is stored as 9.
- `start`: in IDLE or PAUSE, the state becomes RUN only if the count ≠ 0:00; otherwise it is ignored. It is ignored in RUN and DONE.
- `stop`: in RUN, the state becomes PAUSE. It is ignored elsewhere.
- `tick` in RUN decrements the count by one second using BCD borrow:
  - `sec_ones` 0 → 9 with a borrow into `sec_tens`.
  - `sec_tens` 0 → 5 with a borrow into `min`.
  - Otherwise the affected digit decrements by 1.
- If the decrement produces 0:00, the state becomes DONE and `done` pulses high in the same cycle the digits show 0:00.
- `tick` is ignored outside RUN, and on any cycle where a higher-priority control is asserted.
- DONE holds 0:00. It is left only by `load` or `clear`; a `start` in DONE is ignored.
- Digits never leave the legal BCD range. No wrap-around below 0:00.

## Timing
- Reset (`rst_n`=0, asynchronous): `min`=`sec_tens`=`sec_ones`=0, `running`=0, `done`=0, state IDLE. Release is taken synchronously on the next `clk` edge.
- Latency:
  - `load`, `clear`, `start` and `stop` take effect on the digit and state registers at the clock edge where they are sampled, so the outputs show the change one cycle after assertion.
  - A `tick` sampled at edge N updates the digits at edge N, visible immediately after.
- `running` is a registered decode of state==RUN. `done` is registered and high for exactly one cycle.
- `start` and `tick` in the same cycle from PAUSE: state → RUN with no decrement that cycle.
- `stop` and `tick` in the same cycle in RUN: state → PAUSE with no decrement.
- Reset asserted mid-RUN: immediate return to 0:00 / IDLE. No `done` pulse.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → outputs 0:00, `running`=0, `done`=0; release, idle 5 cycles → unchanged.
- Load 2:18, start, apply 3 ticks → digits 2:17, 2:16, 2:15; `running`=1 throughout.
- Borrow chain: load 1:00, start, 1 tick → 0:59. Load 2:10, start, 11 ticks → 1:59.
- Completion: load 0:02, start, 2 ticks → 0:01, then 0:00 with `done`=1 for one cycle; state DONE, `running`=0. A further tick and `start` leave 0:00 and `done`=0.
- Pause and priority: in RUN at 1:59, assert `stop` together with `tick` → PAUSE at 1:59; 3 ticks → unchanged; `start` → RUN; next tick → 1:58. Asserting `load` while running → ignored.
- Sanitising and edge cases:
  - Load 12:7F (digits 12, 7, 15) → 9:59.
  - `start` at 0:00 → stays IDLE.
  - `clear` during RUN → 0:00, IDLE.
  - `rst_n` pulled low mid-RUN, between edges → outputs zero asynchronously.
